eviction_write_buffer: RTL
==========================

Name: eviction_write_buffer

Overview:
- Posted write-back buffer directly downstream of victim_cache. It sits between the victim cache's pmem_* side and physical memory.
- Absorbs dirty-line evictions in one cycle, then drains them to physical memory in FIFO order when the memory port is idle.
- Read misses from the victim cache are serviced from buffered lines when the line address matches; otherwise they are forwarded to physical memory.

Parameters:
- DEPTH, 4, number of 128-bit line entries. Must be a power of two, minimum 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_read  input  1  line read request from victim_cache (its pmem_read).
- mem_write  input  1  line write request from victim_cache (its pmem_write).
- mem_address  input  16  lc3b_word line address; bits [3:0] ignored.
- mem_wdata  input  128  lc3b_mem_data line to write.
- mem_resp  output  1  one-cycle completion pulse to victim_cache.
- mem_rdata  output  128  registered read line, valid while mem_resp=1.
- pmem_read  output  1  read to physical memory.
- pmem_write  output  1  write to physical memory.
- pmem_address  output  16  physical address, bits [3:0] forced to 0.
- pmem_wdata  output  128  head entry data.
- pmem_rdata  input  128  physical memory read data.
- pmem_resp  input  1  physical memory completion.
- buf_empty  output  1  no valid entries.
- buf_full  output  1  count == DEPTH.

Behaviour:
- Tag: each entry holds {valid, tag = address[15:4], data}. Match = valid && tag == mem_address[15:4]. At most one entry matches any tag.
- Ordering: FIFO with head/tail pointers of width $clog2(DEPTH) that wrap modulo DEPTH. Count is 0..DEPTH.
- States and transitions:
  - IDLE, priority order:
    - mem_write with match: overwrite that entry's data in place (coalesce), count unchanged -> RESP.
    - mem_write with no match and not full: write at tail, tail++, count++ -> RESP.
    - mem_write with no match and full: -> DRAIN. The request stays pending and is re-evaluated in IDLE after the drain.
    - mem_read with match: mem_rdata <= entry data -> RESP. No memory access.
    - mem_read with no match: -> FILL.
    - No request and not empty: -> DRAIN.
    - Otherwise stay in IDLE.
  - DRAIN:
    - Outputs: pmem_write=1, pmem_address={head tag,4'b0}, pmem_wdata=head data.
    - On pmem_resp: clear head valid, head++, count-- -> IDLE.
    - Upstream requests are not accepted during DRAIN.
  - FILL:
    - Outputs: pmem_read=1, pmem_address={mem_address[15:4],4'b0}.
    - On pmem_resp: mem_rdata <= pmem_rdata -> RESP.
  - RESP: mem_resp=1 for exactly one cycle -> IDLE.
- Latency:
  - Write hit or non-full write: mem_resp in the cycle after the request is seen.
  - Read hit: mem_resp in the cycle after the request is seen.
  - Read miss: mem_resp in the cycle after pmem_resp.
- Simultaneous mem_read and mem_write is illegal upstream; if both are seen, the write takes priority.
- pmem_read and pmem_write are never both 1. The outputs are Moore decodes of the state.
- Reset (asynchronous, any state including mid-DRAIN or mid-FILL):
  - State returns to IDLE; all valid bits, pointers and count clear.
  - mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, mem_rdata=0.
  - buf_empty=1, buf_full=0.
  - Entries not yet drained are discarded.
- Consistency: because reads check the buffer first and the buffer holds only the newest copy of a line, a read never returns stale memory data for a buffered line.

Decomposition:
- Add to lc3b_types:
  - lc3b_line_tag (logic [11:0]).
  - wb_state_t enum {WB_IDLE, WB_RESP, WB_DRAIN, WB_FILL}.
  - LC3B_LINE_OFFSET_BITS = 4.
- Sub-module eviction_buffer_array holds the storage, valid bits, head/tail/count and the parallel tag compare. It outputs hit, hit_index, head entry, full and empty.
- The top level holds the FSM and the mem_rdata register.

Test Plan:
- Write 0x1230 with data A, empty buffer -> mem_resp at cycle+1, no pmem activity during the request. When idle, DRAIN drives pmem_write with address 0x1230 and data A; after pmem_resp, buf_empty=1.
- Write 0x2000 with data B, then read 0x2005 before the drain -> mem_rdata=B at cycle+1, pmem_read never asserted.
- Read 0x4440 with buffer empty -> pmem_read with address 0x4440; pmem_resp with data C after 5 cycles -> mem_resp one cycle later with mem_rdata=C.
- Fill 4 lines (0x0000, 0x0010, 0x0020, 0x0030) with pmem_resp held low, then write 0x0040 -> buf_full=1 and the block enters DRAIN for 0x0000. After pmem_resp, 0x0040 is accepted at the tail with one further mem_resp; drain order is 0x0010, 0x0020, 0x0030, 0x0040.
- Write 0x1230 with A, then 0x1238 with D before the drain -> count stays 1; the drain writes D only.
- Assert reset_n=0 mid-DRAIN with 3 entries -> pmem_write falls immediately, buf_empty=1, and no drain occurs after release.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types used by the eviction write buffer.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_mem_data;
   typedef logic [11:0]  lc3b_line_tag;

   // Write-buffer controller states.
   typedef enum logic [1:0] {
      WB_IDLE,
      WB_RESP,
      WB_DRAIN,
      WB_FILL
   } wb_state_t;

   // Number of byte-offset bits inside a 16-byte line.
   localparam int LC3B_LINE_OFFSET_BITS = 4;

   // Line tag of a byte address (drops the in-line offset).
   function automatic lc3b_line_tag line_tag(input lc3b_word addr);
      return addr[15:LC3B_LINE_OFFSET_BITS];
   endfunction

   // Line-aligned physical address for a tag.
   function automatic lc3b_word line_address(input lc3b_line_tag tag);
      return {tag, {LC3B_LINE_OFFSET_BITS{1'b0}}};
   endfunction

endpackage

// File: rtl/eviction_buffer_array.sv
// Storage for the eviction write buffer: line data, tags, valid bits,
// FIFO head/tail/count and the parallel tag compare used by lookups.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module eviction_buffer_array
   import lc3b_types::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  lc3b_line_tag       lookup_tag,
   input  lc3b_mem_data       wdata,
   input  logic               push,
   input  logic               update,
   input  logic [PTR_W-1:0]   update_index,
   input  logic               pop,
   output logic               hit,
   output logic [PTR_W-1:0]   hit_index,
   output lc3b_mem_data       hit_data,
   output lc3b_line_tag       head_tag,
   output lc3b_mem_data       head_data,
   output logic               full,
   output logic               empty
);

   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(DEPTH);

   lc3b_mem_data        data_q  [DEPTH];
   lc3b_line_tag        tag_q   [DEPTH];
   logic [DEPTH-1:0]    valid_q;
   logic [PTR_W-1:0]    head_q;
   logic [PTR_W-1:0]    tail_q;
   logic [PTR_W:0]      count_q;

   // Parallel tag compare; the controller never lets two entries share a tag.
   always_comb begin
      hit       = 1'b0;
      hit_index = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (tag_q[i] == lookup_tag)) begin
            hit       = 1'b1;
            hit_index = PTR_W'(i);
         end
      end
   end

   assign hit_data  = data_q[hit_index];
   assign head_tag  = tag_q[head_q];
   assign head_data = data_q[head_q];
   assign full      = (count_q == CNT_MAX);
   assign empty     = (count_q == '0);

   // Line data: appended at the tail or coalesced into a matching entry.
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[tail_q] <= wdata;
      end else if (update) begin
         data_q[update_index] <= wdata;
      end
   end

   // Valid bits, tags and FIFO bookkeeping; reset discards every entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         if (push) begin
            valid_q[tail_q] <= 1'b1;
            tag_q[tail_q]   <= lookup_tag;
            tail_q          <= tail_q + PTR_ONE;
         end
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= head_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/eviction_write_buffer.sv
// Posted write-back buffer between the victim cache and physical memory.
// Evictions are absorbed in one cycle and drained in FIFO order whenever
// the upstream side is quiet; read misses are served from buffered lines
// when the line is present, otherwise forwarded to memory.
//
// Handshake: upstream holds mem_read/mem_write (with address/data) until it
// sees the one-cycle mem_resp pulse and must drop the request on the cycle
// after that pulse. Downstream, pmem_read/pmem_write stay asserted with
// stable address/data until pmem_resp is seen at a rising edge.
module eviction_write_buffer
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [15:0]  mem_address,
   input  logic [127:0] mem_wdata,
   output logic         mem_resp,
   output logic [127:0] mem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp,
   output logic         buf_empty,
   output logic         buf_full
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_state_t           state;
   wb_state_t           next_state;

   logic                hit;
   logic [PTR_W-1:0]    hit_index;
   lc3b_mem_data        hit_data;
   lc3b_line_tag        head_tag;
   lc3b_mem_data        head_data;
   lc3b_line_tag        req_tag;

   logic                push;
   logic                update;
   logic                pop;
   logic                load_hit;
   logic                load_fill;
   logic                addr_offset_unused;

   assign req_tag            = line_tag(mem_address);
   assign addr_offset_unused = ^mem_address[LC3B_LINE_OFFSET_BITS-1:0];

   eviction_buffer_array #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_array (
      .clk          (clk),
      .reset_n      (reset_n),
      .lookup_tag   (req_tag),
      .wdata        (mem_wdata),
      .push         (push),
      .update       (update),
      .update_index (hit_index),
      .pop          (pop),
      .hit          (hit),
      .hit_index    (hit_index),
      .hit_data     (hit_data),
      .head_tag     (head_tag),
      .head_data    (head_data),
      .full         (buf_full),
      .empty        (buf_empty)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= WB_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and buffer control; a write wins over a simultaneous read.
   always_comb begin
      next_state = state;
      push       = 1'b0;
      update     = 1'b0;
      pop        = 1'b0;
      load_hit   = 1'b0;
      load_fill  = 1'b0;
      case (state)
         WB_IDLE: begin
            if (mem_write) begin
               if (hit) begin
                  update     = 1'b1;
                  next_state = WB_RESP;
               end else if (!buf_full) begin
                  push       = 1'b1;
                  next_state = WB_RESP;
               end else begin
                  // Request stays pending; retried here once a slot frees.
                  next_state = WB_DRAIN;
               end
            end else if (mem_read) begin
               if (hit) begin
                  load_hit   = 1'b1;
                  next_state = WB_RESP;
               end else begin
                  next_state = WB_FILL;
               end
            end else if (!buf_empty) begin
               next_state = WB_DRAIN;
            end
         end
         WB_DRAIN: begin
            if (pmem_resp) begin
               pop        = 1'b1;
               next_state = WB_IDLE;
            end
         end
         WB_FILL: begin
            if (pmem_resp) begin
               load_fill  = 1'b1;
               next_state = WB_RESP;
            end
         end
         WB_RESP: begin
            next_state = WB_IDLE;
         end
         default: begin
            next_state = WB_IDLE;
         end
      endcase
   end

   // Registered read line, from the buffer on a hit or memory on a fill.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_rdata <= '0;
      end else if (load_hit) begin
         mem_rdata <= hit_data;
      end else if (load_fill) begin
         mem_rdata <= pmem_rdata;
      end
   end

   // Moore output decode; address/data are zero outside DRAIN and FILL.
   always_comb begin
      mem_resp     = (state == WB_RESP);
      pmem_write   = (state == WB_DRAIN);
      pmem_read    = (state == WB_FILL);
      pmem_address = '0;
      pmem_wdata   = '0;
      if (state == WB_DRAIN) begin
         pmem_address = line_address(head_tag);
         pmem_wdata   = head_data;
      end else if (state == WB_FILL) begin
         pmem_address = line_address(req_tag);
      end
   end

endmodule
